// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, datapath width and sequencer state encoding
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving a combinational ALU
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_opcode,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_opcode_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q      <= cmd_use_acc ? acc_q : cmd_a;
            alu_b_q      <= cmd_b;
            alu_opcode_q <= cmd_opcode;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // ALU operands have been stable for a full cycle, so its result is settled here
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          acc_q        <= alu_result;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign acc_value  = acc_q;
  assign op_count   = op_count_q;

endmodule
